spi_frame_master: RTL and testbench

SPI mode-0 master that serializes one 32-bit bus write into the team's byte-framed SPI slave-bridge protocol. Each byte is its own CS-low window: command 8'h01 followed by four address bytes, then command 8'h02 followed by four data bytes. It sits on the system side, for example in a test chip or FPGA harness, and drives the slave bridge of another device. It is the initiator for the SPI slave write bridge.

---
 rtl/spi_frame_master_if.sv | 27 ++
 rtl/spi_frame_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_master_if.sv
// Bus-side request/handshake bundle between a write requester and spi_frame_master.
interface spi_frame_master_if;
  logic        i_req;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_req,
    output i_addr,
    output i_wr_data,
    input  o_ready,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_req,
    input  i_addr,
    input  i_wr_data,
    output o_ready,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/spi_frame_master.sv
// SPI mode-0 master sending one 32-bit write as ten byte-framed CS windows (01 + addr, 02 + data).
// Optional SPI_FRAME_ADDR_CACHE_EN skips the address phase when the address repeats.
module spi_frame_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_frame_master_if.slave  bus,
  output logic               sclk,
  output logic               cs,
  output logic               mosi
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [3:0] LAST_IDX  = 4'd9;
  localparam logic [3:0] ADDR_LAST = 4'd4;
  localparam logic [3:0] DATA_CMD  = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CS_SETUP = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_HOLD  = 3'd4,
    S_GAP      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_addr;
  logic [31:0]        r_data;
  logic [7:0]         r_shift;
  logic [DIV_W-1:0]   r_div;
  logic [GAP_W-1:0]   r_gap;
  logic [2:0]         r_bit;
  logic [3:0]         r_idx;
  logic               r_sclk;
  logic               r_cs;
  logic               r_mosi;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         w_byte;
  logic [3:0]         w_start_idx;
  logic               w_accept;
  logic               w_div_end;
  logic               w_gap_end;
  logic               w_last_byte;
  logic               w_bit_last;

  assign w_accept    = (r_state == S_IDLE) && bus.i_req;
  assign w_div_end   = (r_div == DIV_LAST);
  assign w_gap_end   = (r_gap == GAP_LAST);
  assign w_last_byte = (r_idx == LAST_IDX);
  assign w_bit_last  = (r_bit == 3'd7);

`ifdef SPI_FRAME_ADDR_CACHE_EN
  logic [31:0] r_cache_addr;
  logic        r_cache_vld;

  // A repeated address starts the frame at the data command byte.
  assign w_start_idx = (r_cache_vld && (bus.i_addr == r_cache_addr)) ? DATA_CMD : 4'd0;

  // Remember the address once its phase has fully gone out on the wire.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cache_vld  <= 1'b0;
      r_cache_addr <= 32'h0000_0000;
    end else if ((r_state == S_GAP) && w_gap_end && (r_idx == ADDR_LAST)) begin
      r_cache_vld  <= 1'b1;
      r_cache_addr <= r_addr;
    end else begin
      r_cache_vld  <= r_cache_vld;
      r_cache_addr <= r_cache_addr;
    end
  end
`else
  assign w_start_idx = 4'd0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; corrupted encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_LOAD;
        else          w_state_nxt = S_IDLE;
      end
      S_LOAD: w_state_nxt = S_CS_SETUP;
      S_CS_SETUP: begin
        if (w_div_end) w_state_nxt = S_SHIFT;
        else           w_state_nxt = S_CS_SETUP;
      end
      S_SHIFT: begin
        if (w_div_end && !r_sclk && w_bit_last) w_state_nxt = S_CS_HOLD;
        else                                    w_state_nxt = S_SHIFT;
      end
      S_CS_HOLD: begin
        if (w_div_end) w_state_nxt = S_GAP;
        else           w_state_nxt = S_CS_HOLD;
      end
      S_GAP: begin
        if (!w_gap_end)       w_state_nxt = S_GAP;
        else if (w_last_byte) w_state_nxt = S_DONE;
        else                  w_state_nxt = S_LOAD;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame byte selection by index.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = 8'h01;
      4'd1:    w_byte = r_addr[31:24];
      4'd2:    w_byte = r_addr[23:16];
      4'd3:    w_byte = r_addr[15:8];
      4'd4:    w_byte = r_addr[7:0];
      4'd5:    w_byte = 8'h02;
      4'd6:    w_byte = r_data[31:24];
      4'd7:    w_byte = r_data[23:16];
      4'd8:    w_byte = r_data[15:8];
      4'd9:    w_byte = r_data[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  // Datapath, SPI pins and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= 32'h0000_0000;
      r_data  <= 32'h0000_0000;
      r_shift <= 8'h00;
      r_div   <= '0;
      r_gap   <= '0;
      r_bit   <= 3'd0;
      r_idx   <= 4'd0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= bus.i_addr;
            r_data <= bus.i_wr_data;
            r_idx  <= w_start_idx;
          end
        end
        S_LOAD: begin
          r_shift <= w_byte;
          r_mosi  <= w_byte[7];
          r_cs    <= 1'b0;
          r_div   <= '0;
        end
        S_CS_SETUP: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_sclk <= 1'b1;
            r_bit  <= 3'd0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + DIV_W'(1);
          end else if (r_sclk) begin
            // Falling edge: present the next bit for the coming rise.
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_shift <= {r_shift[6:0], 1'b0};
            r_mosi  <= r_shift[6];
          end else if (!w_bit_last) begin
            r_div  <= '0;
            r_sclk <= 1'b1;
            r_bit  <= r_bit + 3'd1;
          end else begin
            r_div <= '0;
          end
        end
        S_CS_HOLD: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_cs   <= 1'b1;
            r_mosi <= 1'b0;
            r_gap  <= '0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (!w_gap_end) begin
            r_gap <= r_gap + GAP_W'(1);
          end else if (!w_last_byte) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_DONE: begin
          r_cs   <= 1'b1;
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
        end
        default: begin
          r_cs   <= 1'b1;
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
        end
      endcase
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign sclk        = r_sclk;
  assign cs          = r_cs;
  assign mosi        = r_mosi;
  assign bus.o_ready = r_ready;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: default-timing DUT plus a CLK_DIV=2/CS_GAP=4 DUT for mode-0 timing.
module tb_spi_frame_master;

  logic        clk;
  logic        rst;
  logic        tb_req;
  logic [31:0] tb_addr;
  logic [31:0] tb_data;
  logic        dsel;
  logic        sclk_a, cs_a, mosi_a;
  logic        sclk_b, cs_b, mosi_b;
  logic        m_sclk, m_cs, m_mosi, m_ready, m_busy, m_done;

  int          total;
  int          bad;
  logic [7:0]  got[$];
  int          windows;
  int          done_cyc;
  int          busy_bad;
  bit          aborted;

  spi_frame_master_if if_a ();
  spi_frame_master_if if_b ();

  assign if_a.i_req     = tb_req & ~dsel;
  assign if_a.i_addr    = tb_addr;
  assign if_a.i_wr_data = tb_data;
  assign if_b.i_req     = tb_req & dsel;
  assign if_b.i_addr    = tb_addr;
  assign if_b.i_wr_data = tb_data;

  spi_frame_master u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if_a),
    .sclk  (sclk_a),
    .cs    (cs_a),
    .mosi  (mosi_a)
  );

  spi_frame_master #(.CLK_DIV(2), .CS_GAP(4)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if_b),
    .sclk  (sclk_b),
    .cs    (cs_b),
    .mosi  (mosi_b)
  );

  always_comb begin
    m_sclk  = dsel ? sclk_b       : sclk_a;
    m_cs    = dsel ? cs_b         : cs_a;
    m_mosi  = dsel ? mosi_b       : mosi_a;
    m_ready = dsel ? if_b.o_ready : if_a.o_ready;
    m_busy  = dsel ? if_b.o_busy  : if_a.o_busy;
    m_done  = dsel ? if_b.o_done  : if_a.o_done;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [79:0] exp, input int nbytes);
    logic [7:0] ob;
    check({tag, "_len"}, 32'(got.size()), 32'(nbytes));
    for (int i = 0; i < nbytes; i++) begin
      ob = (i < got.size()) ? got[i] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), 32'(ob), 32'(exp[8*(nbytes-1-i) +: 8]));
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_addr = a;
    tb_data = d;
    tb_req  = 1'b1;
  endtask

  // Follows one frame from the accept edge: sample n is cycle n after accept.
  task automatic watch(input int budget, input bit hold, input bit tchk, input int cd, input int gp,
                       input int poke_at, input int rst_win);
    logic       p_sclk, p_cs, p_mosi;
    logic [7:0] sh;
    int         nb, since_sclk, since_mosi, cs_hi;
    got.delete();
    windows = 0; done_cyc = 0; busy_bad = 0; aborted = 1'b0;
    p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0; sh = 8'h00;
    nb = 0; since_sclk = 0; since_mosi = 0; cs_hi = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      since_sclk++;
      since_mosi++;
      if (!hold && n == 1) tb_req = 1'b0;
      if (n == poke_at) begin
        tb_req  = 1'b1;
        tb_addr = 32'hFFFF_FFFF;
        tb_data = 32'h0000_0000;
      end else if (poke_at != 0 && n == poke_at + 1) begin
        tb_req = 1'b0;
      end
      if (m_busy !== 1'b1 || m_ready !== 1'b0) busy_bad++;
      if (m_mosi !== p_mosi) begin
        since_mosi = 0;
        if (tchk) check("mosi_change_sclk_low", 32'(m_sclk), 32'd0);
      end
      if (m_cs !== p_cs) begin
        if (tchk) check("cs_edge_sclk_low", 32'(m_sclk), 32'd0);
        if (m_cs === 1'b0) begin
          windows++;
          since_sclk = 0;
          if (tchk && windows > 1) check("cs_high_len", 32'(cs_hi), 32'(gp + 1));
        end else begin
          cs_hi = 0;
        end
      end
      if (m_cs === 1'b1) cs_hi++;
      if (m_sclk === 1'b1 && p_sclk === 1'b0) begin
        if (tchk) begin
          check("sclk_low_len", 32'(since_sclk), 32'(cd));
          check("mosi_setup", 32'(since_mosi >= cd), 32'd1);
        end
        sh = {sh[6:0], m_mosi};
        nb++;
        if (nb == 8) begin
          got.push_back(sh);
          nb = 0;
        end
        since_sclk = 0;
      end else if (m_sclk === 1'b0 && p_sclk === 1'b1) begin
        if (tchk) check("sclk_high_len", 32'(since_sclk), 32'(cd));
        since_sclk = 0;
      end
      p_sclk = m_sclk;
      p_cs   = m_cs;
      p_mosi = m_mosi;
      if (rst_win != 0 && windows == rst_win && m_sclk === 1'b1) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_cs", 32'(m_cs), 32'd1);
        check("rst_sclk", 32'(m_sclk), 32'd0);
        check("rst_mosi", 32'(m_mosi), 32'd0);
        check("rst_ready", 32'(m_ready), 32'd1);
        check("rst_busy", 32'(m_busy), 32'd0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (m_done === 1'b1) begin
        done_cyc = n;
        break;
      end
    end
    if (!aborted) check("done_seen", 32'(done_cyc != 0), 32'd1);
    check("busy_not_ready_in_frame", 32'(busy_bad), 32'd0);
  endtask

  initial begin
    int idle_bad;
    total = 0; bad = 0;
    rst = 1'b1; tb_req = 1'b0; tb_addr = 32'h0; tb_data = 32'h0; dsel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cs", 32'(cs_a), 32'd1);
    check("reset_sclk", 32'(sclk_a), 32'd0);
    check("reset_mosi", 32'(mosi_a), 32'd0);
    check("reset_ready", 32'(if_a.o_ready), 32'd1);
    check("reset_busy", 32'(if_a.o_busy), 32'd0);
    check("reset_done", 32'(if_a.o_done), 32'd0);
    check("reset_b_cs", 32'(cs_b), 32'd1);

    // Single write at default timing.
    start(32'h1000_0004, 32'hDEAD_BEEF);
    watch(1000, 1'b0, 1'b0, 4, 8, 0, 0);
    check_frame("single", 80'h01_1000_0004_02_DEAD_BEEF, 10);
    check("single_windows", 32'(windows), 32'd10);
    check("single_done_cycle", 32'(done_cyc), 32'd811);
    @(negedge clk);
    check("single_ready_after", 32'(m_ready), 32'd1);
    check("single_done_one_cycle", 32'(m_done), 32'd0);

    // Mode-0 timing with CLK_DIV=2, CS_GAP=4: per byte 1+2+32+2+4 = 41 cycles.
    dsel = 1'b1;
    start(32'h1000_0004, 32'hDEAD_BEEF);
    watch(600, 1'b0, 1'b1, 2, 4, 0, 0);
    check_frame("fast", 80'h01_1000_0004_02_DEAD_BEEF, 10);
    check("fast_done_cycle", 32'(done_cyc), 32'd411);
    @(negedge clk);
    dsel = 1'b0;

    // Busy: a pulsed request and changed inputs mid-frame must not disturb it.
    start(32'h0000_0000, 32'hCAFE_F00D);
    watch(1000, 1'b0, 1'b0, 4, 8, 200, 0);
    check_frame("busy", 80'h01_0000_0000_02_CAFE_F00D, 10);
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_cs !== 1'b1 || m_busy !== 1'b0) idle_bad++;
    end
    check("busy_req_not_queued", 32'(idle_bad), 32'd0);

    // Reset inside the third byte, then a clean frame.
    start(32'h5555_AAAA, 32'h1234_5678);
    watch(1000, 1'b0, 1'b0, 4, 8, 0, 3);
    check("rst_aborted", 32'(aborted), 32'd1);
    start(32'h0000_0000, 32'h0000_0001);
    watch(1000, 1'b0, 1'b0, 4, 8, 0, 0);
    check_frame("post_rst", 80'h01_0000_0000_02_0000_0001, 10);
    @(negedge clk);

    // Request held high across three back-to-back writes.
    start(32'h2000_0000, 32'h0000_0011);
    watch(1000, 1'b1, 1'b0, 4, 8, 0, 0);
    check_frame("held1", 80'h01_2000_0000_02_0000_0011, 10);
    tb_data = 32'h0000_0022;
    @(negedge clk);
    check("held1_ready", 32'(m_ready), 32'd1);
    watch(1000, 1'b1, 1'b0, 4, 8, 0, 0);
`ifdef SPI_FRAME_ADDR_CACHE_EN
    check_frame("held2", 80'h02_0000_0022, 5);
    check("held2_done_cycle", 32'(done_cyc), 32'd406);
`else
    check_frame("held2", 80'h01_2000_0000_02_0000_0022, 10);
    check("held2_done_cycle", 32'(done_cyc), 32'd811);
`endif
    tb_addr = 32'h2000_0004;
    tb_data = 32'h0000_0033;
    @(negedge clk);
    check("held2_ready", 32'(m_ready), 32'd1);
    watch(1000, 1'b0, 1'b0, 4, 8, 0, 0);
    check_frame("held3", 80'h01_2000_0004_02_0000_0033, 10);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
